// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: MEM/WB pipeline latch with memtoreg writeback mux, write bypass and retire counter
//
// Ports:
//    clk, rst            rising-edge clock, synchronous active-high reset
//    mem_valid           MEM stage holds a real instruction
//    mem_wb_ctl          {regwrite, memtoreg} from EX/MEM
//    mem_read_data       data memory read result
//    mem_alu_result      ALU result passed through MEM
//    mem_write_reg       destination register
//    hold, flush         stall latch / load bubble (flush wins)
//    MEM_WB_*            register-file write port and latched memtoreg
//    wb_valid            WB holds a real instruction
//    fwd_*               one-cycle-delayed copy of the last committed write
//    retire_count        saturating retired count (WB_RETIRE_CNT_EN), else 0
//
// Build option: define WB_RETIRE_CNT_EN to include the retirement counter.
module mem_wb_writeback #(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mem_valid,
   input  logic [1:0]          mem_wb_ctl,
   input  logic [31:0]         mem_read_data,
   input  logic [31:0]         mem_alu_result,
   input  logic [4:0]          mem_write_reg,
   input  logic                hold,
   input  logic                flush,
   output logic                MEM_WB_regwrite,
   output logic [4:0]          MEM_WB_rd,
   output logic [31:0]         WB_mux5_writedata,
   output logic                MEM_WB_memtoreg,
   output logic                wb_valid,
   output logic                fwd_valid,
   output logic [4:0]          fwd_rd,
   output logic [31:0]         fwd_data,
   output logic [RETIRE_W-1:0] retire_count
);
   logic        wb_valid_q, wb_valid_d;
   logic        regwrite_q, regwrite_d;
   logic        memtoreg_q, memtoreg_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] data_q, data_d;
   logic        fresh_q, fresh_d;
   logic        fwd_valid_q, fwd_valid_d;
   logic [4:0]  fwd_rd_q, fwd_rd_d;
   logic [31:0] fwd_data_q, fwd_data_d;
   logic        fwd_hit;
   always_comb begin
      wb_valid_d  = flush ? 1'b0 : hold ? wb_valid_q : mem_valid;
      // register 0 is never written, but the entry still retires
      regwrite_d  = flush ? 1'b0 : hold ? regwrite_q
                  : mem_valid & mem_wb_ctl[1] & (mem_write_reg != 5'd0);
      memtoreg_d  = flush ? 1'b0 : hold ? memtoreg_q : mem_wb_ctl[0];
      rd_d        = flush ? 5'd0 : hold ? rd_q : mem_write_reg;
      data_d      = flush ? 32'd0 : hold ? data_q
                  : (mem_wb_ctl[0] ? mem_read_data : mem_alu_result);
      // fresh marks the first cycle an entry sits in WB, so held entries
      // bypass and retire only once
      fresh_d     = ~flush & ~hold & mem_valid;
      fwd_hit     = regwrite_q & fresh_q;
      fwd_valid_d = fwd_hit;
      fwd_rd_d    = fwd_hit ? rd_q : fwd_rd_q;
      fwd_data_d  = fwd_hit ? data_q : fwd_data_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid_q  <= 1'b0;
         regwrite_q  <= 1'b0;
         memtoreg_q  <= 1'b0;
         rd_q        <= 5'd0;
         data_q      <= 32'd0;
         fresh_q     <= 1'b0;
         fwd_valid_q <= 1'b0;
         fwd_rd_q    <= 5'd0;
         fwd_data_q  <= 32'd0;
      end else begin
         wb_valid_q  <= wb_valid_d;
         regwrite_q  <= regwrite_d;
         memtoreg_q  <= memtoreg_d;
         rd_q        <= rd_d;
         data_q      <= data_d;
         fresh_q     <= fresh_d;
         fwd_valid_q <= fwd_valid_d;
         fwd_rd_q    <= fwd_rd_d;
         fwd_data_q  <= fwd_data_d;
      end
   end
   assign wb_valid          = wb_valid_q;
   assign MEM_WB_regwrite   = regwrite_q;
   assign MEM_WB_memtoreg   = memtoreg_q;
   assign MEM_WB_rd         = rd_q;
   assign WB_mux5_writedata = data_q;
   assign fwd_valid         = fwd_valid_q;
   assign fwd_rd            = fwd_rd_q;
   assign fwd_data          = fwd_data_q;
`ifdef WB_RETIRE_CNT_EN
   logic                retire_pulse;
   logic [RETIRE_W-1:0] cnt_q, cnt_d;
   always_comb begin
      retire_pulse = wb_valid_q & fresh_q;
      cnt_d        = (retire_pulse && !(&cnt_q)) ? cnt_q + RETIRE_W'(1) : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
   assign retire_count = cnt_q;
`else
   assign retire_count = '0;
`endif
endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb_mem_wb_writeback: directed self-checking bench for mem_wb_writeback
module tb_mem_wb_writeback;
   logic        clk = 1'b0;
   logic        rst, mem_valid, hold, flush;
   logic [1:0]  mem_wb_ctl;
   logic [31:0] mem_read_data, mem_alu_result;
   logic [4:0]  mem_write_reg;
   logic        MEM_WB_regwrite, MEM_WB_memtoreg, wb_valid, fwd_valid;
   logic [4:0]  MEM_WB_rd, fwd_rd;
   logic [31:0] WB_mux5_writedata, fwd_data;
   logic [3:0]  retire_count;
   int checks = 0;
   int failures = 0;
   int retired = 0;

   mem_wb_writeback #(.RETIRE_W(4)) dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_wb_ctl(mem_wb_ctl),
      .mem_read_data(mem_read_data), .mem_alu_result(mem_alu_result),
      .mem_write_reg(mem_write_reg), .hold(hold), .flush(flush),
      .MEM_WB_regwrite(MEM_WB_regwrite), .MEM_WB_rd(MEM_WB_rd),
      .WB_mux5_writedata(WB_mux5_writedata), .MEM_WB_memtoreg(MEM_WB_memtoreg),
      .wb_valid(wb_valid), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
      .fwd_data(fwd_data), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] rdat,
                        input logic [31:0] alu, input logic [4:0] rd);
      mem_valid = v; mem_wb_ctl = c; mem_read_data = rdat; mem_alu_result = alu; mem_write_reg = rd;
   endtask

   task automatic chk_wb(input string tag, input logic v, input logic rw, input logic [4:0] rd,
                         input logic [31:0] d, input logic m2r);
      chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(v));
      chk({tag, ".regwrite"}, 32'(MEM_WB_regwrite), 32'(rw));
      chk({tag, ".rd"}, 32'(MEM_WB_rd), 32'(rd));
      chk({tag, ".data"}, WB_mux5_writedata, d);
      chk({tag, ".memtoreg"}, 32'(MEM_WB_memtoreg), 32'(m2r));
   endtask

   task automatic chk_fwd(input string tag, input logic v, input logic [4:0] rd, input logic [31:0] d);
      chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(v));
      chk({tag, ".fwd_rd"}, 32'(fwd_rd), 32'(rd));
      chk({tag, ".fwd_data"}, fwd_data, d);
   endtask

   task automatic chk_cnt(input string tag);
`ifdef WB_RETIRE_CNT_EN
      chk({tag, ".retire"}, 32'(retire_count), (retired > 15) ? 32'd15 : 32'(retired));
`else
      chk({tag, ".retire"}, 32'(retire_count), 32'd0);
`endif
   endtask

   initial begin
      rst = 1'b1; hold = 1'b0; flush = 1'b0;
      drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
      step(); step();
      chk_wb("reset", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      chk_fwd("reset", 1'b0, 5'd0, 32'd0);
      chk_cnt("reset");
      rst = 1'b0;
      // ALU op to r8
      drive(1'b1, 2'b10, 32'hFFFF_FFFF, 32'h5, 5'd8);
      step();
      chk_wb("alu", 1'b1, 1'b1, 5'd8, 32'h5, 1'b0);
      chk_fwd("alu", 1'b0, 5'd0, 32'd0);
      drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
      step(); retired = 1;
      chk_fwd("alu_fwd", 1'b1, 5'd8, 32'h5);
      chk_wb("bubble", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      chk_cnt("alu");
      // load to r9
      drive(1'b1, 2'b11, 32'hDEAD_BEEF, 32'h40, 5'd9);
      step();
      chk_wb("load", 1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b1);
      chk_fwd("fwd_drop", 1'b0, 5'd8, 32'h5);
      chk_cnt("bubble");
      // write to $0
      drive(1'b1, 2'b10, 32'd0, 32'h7, 5'd0);
      step(); retired = 2;
      chk_wb("r0", 1'b1, 1'b0, 5'd0, 32'h7, 1'b0);
      chk_fwd("load_fwd", 1'b1, 5'd9, 32'hDEAD_BEEF);
      chk_cnt("load");
      // r4 = 0x11 then hold 3 cycles with different MEM inputs
      drive(1'b1, 2'b10, 32'd0, 32'h11, 5'd4);
      step(); retired = 3;
      chk_wb("r4", 1'b1, 1'b1, 5'd4, 32'h11, 1'b0);
      chk_fwd("r0_nofwd", 1'b0, 5'd9, 32'hDEAD_BEEF);
      chk_cnt("r0");
      drive(1'b1, 2'b11, 32'h99, 32'h98, 5'd5);
      hold = 1'b1;
      step(); retired = 4;
      chk_wb("hold1", 1'b1, 1'b1, 5'd4, 32'h11, 1'b0);
      chk_fwd("hold1", 1'b1, 5'd4, 32'h11);
      chk_cnt("hold1");
      step();
      chk_wb("hold2", 1'b1, 1'b1, 5'd4, 32'h11, 1'b0);
      chk_fwd("hold2", 1'b0, 5'd4, 32'h11);
      chk_cnt("hold2");
      step();
      chk_wb("hold3", 1'b1, 1'b1, 5'd4, 32'h11, 1'b0);
      chk_fwd("hold3", 1'b0, 5'd4, 32'h11);
      chk_cnt("hold3");
      flush = 1'b1;
      step();
      chk_wb("flush_hold", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      chk_fwd("flush_hold", 1'b0, 5'd4, 32'h11);
      chk_cnt("flush_hold");
      // flush of a regwrite entry in MEM while r3 sits fresh in WB
      hold = 1'b0; flush = 1'b0;
      drive(1'b1, 2'b10, 32'd0, 32'h33, 5'd3);
      step();
      chk_wb("r3", 1'b1, 1'b1, 5'd3, 32'h33, 1'b0);
      drive(1'b1, 2'b10, 32'd0, 32'h44, 5'd10);
      flush = 1'b1;
      step(); retired = 5;
      chk_wb("flush", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      chk_fwd("flush_r3", 1'b1, 5'd3, 32'h33);
      chk_cnt("flush_r3");
      flush = 1'b0;
      drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
      step();
      chk_fwd("flushed_nofwd", 1'b0, 5'd3, 32'h33);
      chk_cnt("flushed_noret");
      // reset during hold
      drive(1'b1, 2'b10, 32'd0, 32'h66, 5'd6);
      step();
      chk_wb("r6", 1'b1, 1'b1, 5'd6, 32'h66, 1'b0);
      hold = 1'b1; rst = 1'b1;
      step(); retired = 0;
      chk_wb("rst_hold", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      chk_fwd("rst_hold", 1'b0, 5'd0, 32'd0);
      chk_cnt("rst_hold");
      hold = 1'b0; rst = 1'b0;
      // back-to-back writes to r7
      drive(1'b1, 2'b10, 32'd0, 32'h1, 5'd7);
      step();
      drive(1'b1, 2'b10, 32'd0, 32'h2, 5'd7);
      step(); retired = 1;
      chk_wb("r7b", 1'b1, 1'b1, 5'd7, 32'h2, 1'b0);
      chk_fwd("r7a_fwd", 1'b1, 5'd7, 32'h1);
      drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
      step(); retired = 2;
      chk_fwd("r7b_fwd", 1'b1, 5'd7, 32'h2);
      chk_cnt("r7");
      // 20 back-to-back instructions drive the 4-bit counter into saturation
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 2'b10, 32'd0, 32'(i), 5'(i + 1));
         step();
      end
      retired = 21;
      chk_cnt("burst");
      drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
      step(); retired = 22;
      chk_cnt("saturate");
      step();
      chk_cnt("saturate_hold");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
